// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Multi-digit seven-segment scan controller. A packed hex value is captured
//   into a shadow register on load_in. The digits are then time-multiplexed
//   onto a shared cathode bus, one anode at a time, with REFRESH_CYCLES
//   clocks per digit. The block also does hex glyph decode, per-digit
//   decimal points and optional leading-zero blanking. All outputs are
//   registered, so they show the counter, digit index and shadow state of
//   the previous cycle.
//
//   Optional macro SEG7_BRIGHTNESS_EN adds bright_in[3:0]. With it, each
//   slot is lit only for the first (REFRESH_CYCLES/16)*(bright_in+1) cycles.
//   Without it the duty cycle is 100%.
//
// Ports
//   clk_in       system clock
//   rst_n_in     asynchronous active-low reset (display dark)
//   val_in       packed nibbles, nibble i drives digit i (digit 0 = rightmost)
//   dp_in        decimal-point request per digit
//   load_in      capture val_in / dp_in into the shadow registers
//   blank_lz_in  enable leading-zero blanking (digit 0 is never blanked)
//   bright_in    duty select, 0 = 1/16 .. 15 = full (SEG7_BRIGHTNESS_EN only)
//   cat_out      segment cathodes a..g (bit 0 = a), active-low
//   dp_out       decimal-point cathode, active-low
//   an_out       digit anodes, active-low, one-hot-low while lit
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load_in,
  input  logic                    blank_lz_in,
`ifdef SEG7_BRIGHTNESS_EN
  input  logic [3:0]              bright_in,
`endif
  output logic [6:0]              cat_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out
);

  localparam int CW    = $clog2(REFRESH_CYCLES);
  localparam int IW    = $clog2(NUM_DIGITS);
  localparam int SLICE = REFRESH_CYCLES / 16;

  logic [CW-1:0]                cnt;
  logic [IW-1:0]                idx;
  logic [NUM_DIGITS-1:0][3:0]   sh_val;
  logic [NUM_DIGITS-1:0]        sh_dp;

  // Active-high segment pattern (bit 0 = a .. bit 6 = g).
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  // Scan timing: each digit owns REFRESH_CYCLES consecutive clocks.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(REFRESH_CYCLES - 1)) begin
      cnt <= '0;
      idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow registers: the display never looks at val_in/dp_in directly.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sh_val <= '0;
      sh_dp  <= '0;
    end else if (load_in) begin
      sh_val <= val_in;
      sh_dp  <= dp_in;
    end
  end

  // lz_mask[i] is set when nibbles i..NUM_DIGITS-1 are all zero. This is
  // computed top-down so each bit folds in the digits above it. Bit 0 stays
  // clear, so a zero value still shows a single "0".
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  lz_acc;
  always_comb begin
    lz_mask = '0;
    lz_acc  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_acc     = lz_acc & (sh_val[i] == 4'h0);
      lz_mask[i] = lz_acc;
    end
  end

  // The duty limit is one bit wider than cnt so that REFRESH_CYCLES itself
  // fits. With a full limit, cnt < limit always holds.
  logic [CW:0] duty_lim;
  always_comb begin
`ifdef SEG7_BRIGHTNESS_EN
    duty_lim = (CW+1)'(SLICE * (int'(bright_in) + 1));
`else
    duty_lim = (CW+1)'(SLICE * 16);
`endif
  end

  logic                  lit;
  logic [6:0]            cat_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;
  always_comb begin
    lit     = !(blank_lz_in && lz_mask[idx]) && ({1'b0, cnt} < duty_lim);
    cat_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    an_nxt  = '1;
    if (lit) begin
      cat_nxt = ~glyph(sh_val[idx]);
      dp_nxt  = ~sh_dp[idx];
      an_nxt  = ~(NUM_DIGITS'(1) << idx);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cat_out <= 7'h7F;
      dp_out  <= 1'b1;
      an_out  <= '1;
    end else begin
      cat_out <= cat_nxt;
      dp_out  <= dp_nxt;
      an_out  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Self-checking bench for seg7_scan_driver with NUM_DIGITS=4 and
//   REFRESH_CYCLES=16. The reference model counts the clock edges since
//   reset. The slot owner and position come from plain division. The
//   expected frame for the next edge is built from a glyph table and the
//   shadow value the model keeps. The bench compares the DUT against this
//   model on every falling edge. Literal expectations pin the model at key
//   points.
module tb_seg7_scan_driver;
  localparam int ND = 4;
  localparam int RC = 16;

  logic        clk_in      = 1'b0;
  logic        rst_n_in    = 1'b1;
  logic [15:0] val_in      = '0;
  logic [3:0]  dp_in       = '0;
  logic        load_in     = 1'b0;
  logic        blank_lz_in = 1'b0;
`ifdef SEG7_BRIGHTNESS_EN
  logic [3:0]  bright_in   = 4'hF;
`endif
  logic [6:0]  cat_out;
  logic        dp_out;
  logic [3:0]  an_out;

  int tests = 0;
  int fails = 0;

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_CYCLES(RC)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .val_in(val_in), .dp_in(dp_in),
    .load_in(load_in), .blank_lz_in(blank_lz_in),
`ifdef SEG7_BRIGHTNESS_EN
    .bright_in(bright_in),
`endif
    .cat_out(cat_out), .dp_out(dp_out), .an_out(an_out));

  always #5 clk_in = ~clk_in;

  localparam logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
    7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic int cur_bright();
`ifdef SEG7_BRIGHTNESS_EN
    return int'(bright_in);
`else
    return 15;
`endif
  endfunction

  // Expected {an, dp, cat} for the edge that follows n edges since reset.
  function automatic logic [11:0] model(input int n, input logic [15:0] sh,
                                        input logic [3:0] dsh, input logic bl,
                                        input int br);
    int          digit, pos;
    logic [15:0] upper;
    logic [3:0]  nib;
    logic        blanked;
    digit   = (n / RC) % ND;
    pos     = n % RC;
    upper   = sh >> (4 * digit);
    nib     = upper[3:0];
    blanked = bl && (digit != 0) && (upper == 16'h0);
    if (!blanked && pos < (RC / 16) * (br + 1))
      return {~(4'b0001 << digit), ~dsh[digit], ~GLY[nib]};
    return 12'hFFF;
  endfunction

  int          n_m   = 0;
  logic [15:0] sh_m  = '0;
  logic [3:0]  dsh_m = '0;
  logic [11:0] exp_v = 12'hFFF;

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      n_m <= 0; sh_m <= '0; dsh_m <= '0; exp_v <= 12'hFFF;
    end else begin
      exp_v <= model(n_m, sh_m, dsh_m, blank_lz_in, cur_bright());
      n_m   <= n_m + 1;
      if (load_in) begin
        sh_m  <= val_in;
        dsh_m <= dp_in;
      end
    end
  end

  task automatic check(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    check("scan", int'({an_out, dp_out, cat_out}), int'(exp_v));
  endtask

  task automatic wait_an(input logic [3:0] t);
    int k = 0;
    while (an_out !== t && k < 100) begin tick(); k++; end
    if (an_out !== t) check("wait_an", int'(an_out), int'(t));
  endtask

  function automatic int lit_now();
    return (an_out != 4'hF) ? 1 : 0;
  endfunction

  logic [15:0] sweep [4] = '{16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};

  initial begin
    int c;
    int k;
    #3 rst_n_in = 1'b0;
    repeat (3) tick();
    check("reset_dark", int'({an_out, dp_out, cat_out}), 'hFFF);
    rst_n_in = 1'b1;
    tick();
    check("first_anode", int'({an_out, dp_out, cat_out}), int'({4'b1110, 1'b1, 7'h40}));
    repeat (70) tick();

    // glyph sweep
    foreach (sweep[i]) begin
      val_in = sweep[i]; dp_in = 4'($urandom); load_in = 1'b1;
      tick();
      load_in = 1'b0;
      repeat (64) tick();
      if (i == 1) begin wait_an(4'b1011); check("glyph_A", int'(cat_out), 'h08); end
      if (i == 3) begin wait_an(4'b1101); check("glyph_1", int'(cat_out), 'h79); end
    end

    // leading-zero blanking
    blank_lz_in = 1'b1; val_in = 16'h0050; dp_in = 4'b1000; load_in = 1'b1;
    tick();
    load_in = 1'b0;
    repeat (64) tick();
    wait_an(4'b1101);
    check("lz_digit1", int'({dp_out, cat_out}), int'({1'b1, 7'h12}));
    wait_an(4'b1110);
    check("lz_digit0", int'(cat_out), 'h40);
    c = 0;
    repeat (64) begin tick(); c += lit_now(); end
    check("lz_lit_cycles", c, 32);
    val_in = 16'h0000; load_in = 1'b1;
    tick();
    load_in = 1'b0;
    repeat (16) tick();
    c = 0;
    repeat (64) begin tick(); c += lit_now(); end
    check("lz_zero_cycles", c, 16);

    // shadow isolation
    blank_lz_in = 1'b0; val_in = 16'h1234; dp_in = 4'b0000; load_in = 1'b1;
    tick();
    load_in = 1'b0;
    repeat (64) begin val_in = 16'($urandom); tick(); end
    wait_an(4'b0111);
    check("shadow_digit3", int'(cat_out), 'h79);

    // load on the digit 3 -> digit 0 change edge
    k = 0;
    while (n_m % 64 != 63 && k < 100) begin tick(); k++; end
    val_in = 16'h9ABC; load_in = 1'b1;
    tick();
    load_in = 1'b0;
    tick();
    check("coincident_load", int'({an_out, cat_out}), int'({4'b1110, 7'h46}));

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      val_in = 16'($urandom);
      if ($urandom_range(0, 3) == 0) val_in = val_in & 16'h00FF;
      dp_in   = 4'($urandom);
      load_in = ($urandom_range(0, 5) == 0);
      if (i % 50 == 0) blank_lz_in = 1'($urandom);
`ifdef SEG7_BRIGHTNESS_EN
      if (i % 37 == 0) bright_in = 4'($urandom);
`endif
      tick();
    end
    load_in = 1'b0;
`ifdef SEG7_BRIGHTNESS_EN
    bright_in = 4'hF;
`endif

    // asynchronous reset during digit 2
    val_in = 16'hABCD; load_in = 1'b1;
    tick();
    load_in = 1'b0; blank_lz_in = 1'b0;
    k = 0;
    while (!((n_m / RC) % ND == 2 && n_m % RC == 5) && k < 200) begin tick(); k++; end
    #2 rst_n_in = 1'b0;
    #1 check("async_dark", int'({an_out, dp_out, cat_out}), 'hFFF);
    tick();
    tick();
    rst_n_in = 1'b1;
    tick();
    check("restart_digit0", int'({an_out, cat_out}), int'({4'b1110, 7'h40}));
    c = 1;
    repeat (15) begin tick(); if (an_out == 4'b1110) c++; end
    check("restart_slot_len", c, 16);
    tick();
    check("restart_next", int'(an_out), 'hD);

`ifdef SEG7_BRIGHTNESS_EN
    bright_in = 4'd3;
    c = 0;
    repeat (64) begin tick(); c += lit_now(); end
    check("bright3_cycles", c, 16);
    bright_in = 4'd15;
    repeat (16) tick();
    c = 0;
    repeat (64) begin tick(); c += lit_now(); end
    check("bright15_cycles", c, 64);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
